// File: rtl/dot_product.sv
// Column-correlation engine: for each Phi column, accumulates the signed dot product
// of rows 0..M (4 packed Q10.13 lanes per word) with the residual and emits one result per column.
module dot_product #(
   parameter int DATA_W = 24,
   parameter int LANES  = 4,
   parameter int ACC_W  = 48
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_a,
   input  logic [5:0]                N,
   input  logic [2:0]                M,
   output logic [8:0]                phi_addr,
   input  logic [DATA_W*LANES-1:0]   phi_data,
   output logic [2:0]                r_addr,
   input  logic [DATA_W*LANES-1:0]   r_data,
   output logic [ACC_W-1:0]          dot_result,
   output logic [5:0]                current_col_idx,
   output logic                      col_done,
   output logic                      all_done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]                state;
   logic [5:0]                n_l;
   logic [2:0]                m_l;
   logic [5:0]                col;
   logic [2:0]                row;
   logic                      rd_v, rd_last;
   logic                      prod_v, prod_last;
   logic signed [ACC_W-1:0]   prod [LANES];
   logic [ACC_W-1:0]          acc;
   logic [ACC_W-1:0]          prod_sum;
   logic [ACC_W-1:0]          acc_next;

   always_comb begin
      prod_sum = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         prod_sum = prod_sum + prod[i];
      end
      acc_next = acc + prod_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         n_l             <= '0;
         m_l             <= '0;
         col             <= '0;
         row             <= '0;
         rd_v            <= 1'b0;
         rd_last         <= 1'b0;
         prod_v          <= 1'b0;
         prod_last       <= 1'b0;
         acc             <= '0;
         phi_addr        <= '0;
         r_addr          <= '0;
         dot_result      <= '0;
         current_col_idx <= '0;
         col_done        <= 1'b0;
         all_done        <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) begin
            prod[i] <= '0;
         end
      end else begin
         col_done  <= 1'b0;
         all_done  <= 1'b0;
         // Valid/last flags trail the address by the BRAM and multiplier stages.
         rd_v      <= (state == READ);
         rd_last   <= (state == READ) && (row == m_l);
         prod_v    <= rd_v;
         prod_last <= rd_last;

         for (int unsigned i = 0; i < LANES; i++) begin
            prod[i] <= ACC_W'($signed(phi_data[i*DATA_W +: DATA_W])) *
                       ACC_W'($signed(r_data[i*DATA_W +: DATA_W]));
         end

         if (prod_v) begin
            acc <= prod_last ? '0 : acc_next;
         end

         if (prod_last) begin
            dot_result      <= acc_next;
            current_col_idx <= col;
            col_done        <= 1'b1;
            all_done        <= (col == n_l);
         end

         case (state)
            IDLE: begin
               if (start_a) begin
                  n_l      <= N;
                  m_l      <= M;
                  col      <= '0;
                  row      <= '0;
                  phi_addr <= '0;
                  r_addr   <= '0;
                  state    <= READ;
               end
            end
            READ: begin
               if (row == m_l) begin
                  state <= DRAIN;
               end else begin
                  row      <= row + 3'd1;
                  phi_addr <= {col, row + 3'd1};
                  r_addr   <= row + 3'd1;
               end
            end
            DRAIN: begin
               if (prod_last) begin
                  state <= DONE;
               end
            end
            default: begin
               if (col == n_l) begin
                  state <= IDLE;
               end else begin
                  col      <= col + 6'd1;
                  row      <= '0;
                  phi_addr <= {col + 6'd1, 3'd0};
                  r_addr   <= '0;
                  state    <= READ;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dot_product.sv
// Bench for dot_product: BRAM models with 1-cycle latency, directed and random data,
// results compared against a plain-arithmetic dot-product model.
module tb_dot_product;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_a;
   logic [5:0]    N;
   logic [2:0]    M;
   logic [8:0]    phi_addr;
   logic [95:0]   phi_data;
   logic [2:0]    r_addr;
   logic [95:0]   r_data;
   logic [47:0]   dot_result;
   logic [5:0]    current_col_idx;
   logic          col_done;
   logic          all_done;

   logic [95:0]   phi_mem [0:511];
   logic [95:0]   r_mem   [0:7];
   logic [47:0]   got_res [0:63];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dot_product #(.DATA_W(24), .LANES(4), .ACC_W(48)) dut (
      .clk(clk), .rst_n(rst_n), .start_a(start_a), .N(N), .M(M),
      .phi_addr(phi_addr), .phi_data(phi_data), .r_addr(r_addr), .r_data(r_data),
      .dot_result(dot_result), .current_col_idx(current_col_idx),
      .col_done(col_done), .all_done(all_done)
   );

   always @(posedge clk) begin
      phi_data <= phi_mem[phi_addr];
      r_data   <= r_mem[r_addr];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [47:0] model(input int c, input int m);
      logic [47:0]        acc;
      logic [95:0]        pw, rw;
      logic signed [23:0] a, b;
      acc = '0;
      for (int row = 0; row <= m; row++) begin
         pw = phi_mem[c*8 + row];
         rw = r_mem[row];
         for (int l = 0; l < 4; l++) begin
            a = pw[l*24 +: 24];
            b = rw[l*24 +: 24];
            acc = acc + 48'(longint'(a) * longint'(b));
         end
      end
      return acc;
   endfunction

   task automatic load_directed();
      logic [23:0] v;
      for (int i = 0; i < 8; i++) r_mem[i] = {4{24'h002000}};
      for (int a = 0; a < 512; a++) begin
         case (a / 8)
            0:       v = 24'h002000;
            1:       v = 24'h001000;
            2:       v = 24'hFFE000;
            default: v = 24'h000000;
         endcase
         phi_mem[a] = {4{v}};
      end
   endtask

   function automatic logic [23:0] rand_sample();
      case ($urandom_range(0, 3))
         0:       return 24'h800000;
         1:       return 24'h7FFFFF;
         default: return 24'($urandom);
      endcase
   endfunction

   task automatic load_random();
      for (int i = 0; i < 8; i++)
         r_mem[i] = {rand_sample(), rand_sample(), rand_sample(), rand_sample()};
      for (int a = 0; a < 512; a++)
         phi_mem[a] = {rand_sample(), rand_sample(), rand_sample(), rand_sample()};
   endtask

   // Runs columns 0..n with rows 0..m; checks address trace, pulse timing and results.
   task automatic run(input int n, input int m, input bit disturb);
      logic [47:0] exp [0:63];
      int p, total, pulses, c, k, kk;
      for (int i = 0; i <= n; i++) exp[i] = model(i, m);
      p = m + 4;
      total = (n + 1) * p;
      pulses = 0;
      @(negedge clk);
      start_a = 1'b1; N = 6'(n); M = 3'(m);
      @(negedge clk);
      start_a = 1'b0;
      for (int cyc = 0; cyc < total + 8; cyc++) begin
         c = cyc / p;
         k = cyc % p;
         if (c <= n) begin
            kk = (k <= m) ? k : m;
            check("phi_addr", phi_addr, c*8 + kk);
            check("r_addr", r_addr, kk);
         end
         if (col_done) begin
            check("col_idx", current_col_idx, pulses);
            if (pulses <= n) begin
               check("dot_result", dot_result, exp[pulses]);
               got_res[pulses] = dot_result;
            end
            check("col_time", cyc, pulses*p + m + 3);
            check("all_done", all_done, (pulses == n));
            pulses++;
         end else begin
            check("all_done_stray", all_done, 0);
         end
         if (disturb && cyc == 3) begin
            start_a = 1'b1; N = 6'($urandom); M = 3'($urandom);
         end
         if (disturb && cyc == 4) start_a = 1'b0;
         @(negedge clk);
      end
      check("pulse_count", pulses, n + 1);
   endtask

   initial begin
      int pulses;
      rst_n = 1'b0; start_a = 1'b0; N = '0; M = '0;
      load_directed();
      repeat (3) @(negedge clk);
      check("rst_dot_result", dot_result, 0);
      check("rst_col_idx", current_col_idx, 0);
      check("rst_col_done", col_done, 0);
      check("rst_all_done", all_done, 0);
      check("rst_phi_addr", phi_addr, 0);
      check("rst_r_addr", r_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 4x4 directed
      run(15, 1, 1'b0);
      check("4x4_col0", got_res[0], 48'h000020000000);
      check("4x4_col1", got_res[1], 48'h000010000000);
      check("4x4_col2", got_res[2], 48'hFFFFE0000000);
      check("4x4_col3", got_res[3], 48'h0);
      check("4x4_col15", got_res[15], 48'h0);

      // 8x8 directed
      run(63, 7, 1'b0);
      check("8x8_col0", got_res[0], 48'h000080000000);
      check("8x8_col2", got_res[2], 48'hFFFF80000000);

      // Address trace and mid-run start/N/M disturbance
      run(1, 1, 1'b0);
      run(15, 1, 1'b1);
      run(3, 0, 1'b0);

      // Random data and sizes
      load_random();
      for (int t = 0; t < 6; t++) begin
         run($urandom_range(0, 20), $urandom_range(0, 7), t[0]);
      end
      run(63, 7, 1'b1);

      // Mid-column abort
      load_directed();
      @(negedge clk);
      start_a = 1'b1; N = 6'd3; M = 3'd2;
      @(negedge clk);
      start_a = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_dot_result", dot_result, 0);
      check("abort_col_idx", current_col_idx, 0);
      check("abort_col_done", col_done, 0);
      check("abort_phi_addr", phi_addr, 0);
      check("abort_r_addr", r_addr, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (col_done || all_done) pulses++;
      end
      check("abort_no_pulses", pulses, 0);
      run(2, 1, 1'b0);
      check("abort_fresh_col0", got_res[0], 48'h000020000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
